fsm_shift_combine_param: RTL and testbench
==========================================

// Module: fsm_shift_combine_param
// PURPOSE
//   Parametrised two-operand shift/combine engine with selectable operation.
//   Captures a pair of DATA_W-bit operands when both are valid, then runs a
//   fixed SHIFT -> COMBINE pipeline and presents a 2*DATA_W result.
//   The result is held under a valid/ready output handshake.
//   Sits between two producer channels and one downstream consumer in the
//   datapath.
// PARAMETERS
//   DATA_W   8   operand width in bits; result width is 2*DATA_W
//   SHIFT_W  3   width of shift-amount input; must satisfy 2**SHIFT_W <= 2*DATA_W
//   CNT_W    8   width of the completed-result counter (wraps)
// PORTS
//   clk             in   1          rising-edge clock; the only clock
//   reset           in   1          synchronous, active-low reset
//   data_in1_valid  in   1          operand 1 valid
//   data_in2_valid  in   1          operand 2 valid
//   data_in1        in   DATA_W     operand 1 (A)
//   data_in2        in   DATA_W     operand 2 (B)
//   mode            in   2          op select, sampled at capture
//   shamt           in   SHIFT_W    shift/rotate amount, sampled at capture
//   data_in_ready   out  1          high only in IDLE; capture requires both valids & ready
//   out_ready       in   1          downstream accepts the result
//   data_out        out  2*DATA_W   result register
//   output_valid    out  1          result valid; held until accepted
//   busy            out  1          high in any state except IDLE
//   result_count    out  CNT_W      number of accepted results, wraps modulo 2**CNT_W
// BEHAVIOUR
//   Reset: reset==0 at a clk edge forces state=IDLE, data_out=0,
//     output_valid=0, result_count=0 and clears the operand, mode and shamt
//     registers. Reset overrides everything, including mid-operation and HOLD.
//   States: IDLE, SHIFT, COMBINE, HOLD (2-bit encoding). Illegal encodings go to IDLE.
//   IDLE: data_in_ready=1. If data_in1_valid && data_in2_valid, latch A, B,
//     mode and shamt, then go to SHIFT. If only one valid is high, nothing is
//     captured and the state stays IDLE.
//   SHIFT: compute the intermediate S into an internal register, then go to COMBINE.
//     mode 00: S={A,B}
//     mode 01: S=zero_ext(A)<<shamt
//     mode 10: S={A,B} rotated left by shamt
//     mode 11: S=A*B (unsigned, full 2*DATA_W product)
//   COMBINE: data_out<=S, output_valid<=1, go to HOLD.
//   HOLD: data_out and output_valid are stable. On the edge where out_ready==1:
//     output_valid<=0, result_count<=result_count+1, go to IDLE.
//     With out_ready==0 the block stays in HOLD indefinitely.
//   Latency: capture edge E0 -> output_valid high after edge E0+2.
//     Earliest acceptance is E0+3. Peak throughput is 1 result per 4 cycles.
//   data_out keeps its previous value from capture until the COMBINE edge;
//     it never shows intermediate values.
//   Inputs are ignored (data_in_ready=0) in SHIFT, COMBINE and HOLD.
//     Producers must hold their valid signals until capture.
//   Arithmetic: shifts are logical with zero fill. Rotation width is 2*DATA_W.
//     All results are unsigned and exactly 2*DATA_W bits.
//   out_ready has no effect outside HOLD. result_count wraps from all-ones to 0.
// TESTING (DATA_W=8, SHIFT_W=3, CNT_W=8)
//   T1 mode=00, A=A5, B=3C, both valid one cycle, out_ready=1
//      -> data_out=16'hA53C, valid high 2 edges after capture, result_count=1.
//   T2 mode=01, shamt=2, A=81 -> data_out=16'h0204.
//      mode=01, shamt=7, A=FF -> 16'h7F80.
//   T3 mode=10, shamt=4, A=12, B=34 -> data_out=16'h2341.
//      shamt=0 -> 16'h1234.
//   T4 mode=11, A=FF, B=FF -> 16'hFE01. A=00, B=9C -> 16'h0000.
//   T5 out_ready=0 for 5 cycles after valid; new operands 11/22 presented with both valids
//      -> data_out/output_valid stable, data_in_ready=0, no capture.
//      Then out_ready=1 -> accept, IDLE; pending 11/22 captured next edge.
//   T6 only data_in1_valid high for 3 cycles -> stays IDLE.
//      reset=0 asserted during SHIFT -> next edge: IDLE, data_out=0,
//      output_valid=0, result_count=0; no stale result appears.

Source files
------------

// File: rtl/fsm_shift_combine_param.sv
// Two-operand shift/combine engine: captures A/B when both are valid, runs SHIFT then COMBINE,
// and holds the 2*DATA_W result under a valid/ready handshake until it is accepted.
module fsm_shift_combine_param #(
    parameter int DATA_W  = 8,
    parameter int SHIFT_W = 3,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_in1_valid,
    input  logic                  data_in2_valid,
    input  logic [DATA_W-1:0]     data_in1,
    input  logic [DATA_W-1:0]     data_in2,
    input  logic [1:0]            mode,
    input  logic [SHIFT_W-1:0]    shamt,
    output logic                  data_in_ready,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   data_out,
    output logic                  output_valid,
    output logic                  busy,
    output logic [CNT_W-1:0]      result_count
);

    localparam int RES_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_COMBINE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [1:0]           r_mode;
    logic [SHIFT_W-1:0]   r_shamt;
    logic [RES_W-1:0]     r_s;
    logic [RES_W-1:0]     r_data_out;
    logic                 r_valid;
    logic [CNT_W-1:0]     r_count;

    logic                 w_capture;
    logic                 w_load_s;
    logic                 w_load_out;
    logic                 w_accept;
    logic                 w_ready;
    logic                 w_busy;

    logic [RES_W-1:0]     w_cat;
    logic [RES_W-1:0]     w_shl;
    logic [2*RES_W-1:0]   w_dbl;
    logic [RES_W-1:0]     w_rot;
    logic [RES_W-1:0]     w_prod;
    logic [RES_W-1:0]     w_s_next;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (data_in1_valid && data_in2_valid) w_state_next = ST_SHIFT;
            ST_SHIFT:   w_state_next = ST_COMBINE;
            ST_COMBINE: w_state_next = ST_HOLD;
            ST_HOLD:    if (out_ready) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_ready    = 1'b0;
        w_busy     = 1'b1;
        w_capture  = 1'b0;
        w_load_s   = 1'b0;
        w_load_out = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready   = 1'b1;
                w_busy    = 1'b0;
                w_capture = data_in1_valid && data_in2_valid;
            end
            ST_SHIFT:   w_load_s   = 1'b1;
            ST_COMBINE: w_load_out = 1'b1;
            ST_HOLD:    w_accept   = out_ready;
            default: begin
                w_ready = 1'b0;
                w_busy  = 1'b1;
            end
        endcase
    end

    // Rotation takes the upper half of the doubled operand pair shifted left.
    assign w_cat  = {r_a, r_b};
    assign w_shl  = {{DATA_W{1'b0}}, r_a} << r_shamt;
    assign w_dbl  = {w_cat, w_cat} << r_shamt;
    assign w_rot  = w_dbl[2*RES_W-1:RES_W];
    assign w_prod = {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, r_b};

    always_comb begin
        w_s_next = w_cat;
        case (r_mode)
            2'b00:   w_s_next = w_cat;
            2'b01:   w_s_next = w_shl;
            2'b10:   w_s_next = w_rot;
            default: w_s_next = w_prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_mode     <= '0;
            r_shamt    <= '0;
            r_s        <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_capture) begin
                r_a     <= data_in1;
                r_b     <= data_in2;
                r_mode  <= mode;
                r_shamt <= shamt;
            end
            if (w_load_s) begin
                r_s <= w_s_next;
            end
            if (w_load_out) begin
                r_data_out <= r_s;
                r_valid    <= 1'b1;
            end
            if (w_accept) begin
                r_valid <= 1'b0;
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign data_in_ready = w_ready;
    assign busy          = w_busy;
    assign data_out      = r_data_out;
    assign output_valid  = r_valid;
    assign result_count  = r_count;

endmodule

// File: tb/tb_fsm_shift_combine_param.sv
// Directed bench for fsm_shift_combine_param: table of operations with hand-computed results,
// plus hand-written sequences for back-pressure, partial valids, mid-operation reset and count wrap.
module tb_fsm_shift_combine_param;

    logic        clk;
    logic        reset;
    logic        data_in1_valid;
    logic        data_in2_valid;
    logic [7:0]  data_in1;
    logic [7:0]  data_in2;
    logic [1:0]  mode;
    logic [2:0]  shamt;
    logic        data_in_ready;
    logic        out_ready;
    logic [15:0] data_out;
    logic        output_valid;
    logic        busy;
    logic [7:0]  result_count;

    int checks;
    int failures;

    fsm_shift_combine_param #(.DATA_W(8), .SHIFT_W(3), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in1_valid (data_in1_valid),
        .data_in2_valid (data_in2_valid),
        .data_in1       (data_in1),
        .data_in2       (data_in2),
        .mode           (mode),
        .shamt          (shamt),
        .data_in_ready  (data_in_ready),
        .out_ready      (out_ready),
        .data_out       (data_out),
        .output_valid   (output_valid),
        .busy           (busy),
        .result_count   (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  md;
        logic [2:0]  sh;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction with out_ready=1; inputs are scrambled right after capture
    // so a design that re-samples them after capture is caught.
    task automatic run_vec(input vec_t v, input logic [15:0] prev_out, input logic [7:0] exp_cnt);
        @(negedge clk);
        data_in1 = v.a; data_in2 = v.b; mode = v.md; shamt = v.sh;
        data_in1_valid = 1'b1; data_in2_valid = 1'b1; out_ready = 1'b1;
        chk("ready_before_capture", 32'(data_in_ready), 32'd1);
        @(negedge clk);
        data_in1_valid = 1'b0; data_in2_valid = 1'b0;
        data_in1 = ~v.a; data_in2 = ~v.b; mode = v.md ^ 2'b11; shamt = ~v.sh;
        chk("shift_busy", 32'(busy), 32'd1);
        chk("shift_ready_low", 32'(data_in_ready), 32'd0);
        chk("shift_valid_low", 32'(output_valid), 32'd0);
        @(negedge clk);
        chk("combine_valid_low", 32'(output_valid), 32'd0);
        chk("combine_data_prev", 32'(data_out), 32'(prev_out));
        @(negedge clk);
        chk("hold_valid", 32'(output_valid), 32'd1);
        chk("hold_data", 32'(data_out), 32'(v.exp));
        @(negedge clk);
        chk("accepted_valid_low", 32'(output_valid), 32'd0);
        chk("accepted_count", 32'(result_count), 32'(exp_cnt));
        chk("accepted_idle", 32'(busy), 32'd0);
        $display("op a=%02h b=%02h mode=%0d sh=%0d -> data_out=%04h count=%0d",
                 v.a, v.b, v.md, v.sh, data_out, result_count);
    endtask

    // Quick transaction for the wrap test: fixed 4-cycle cadence, no per-cycle checks.
    task automatic quick_op();
        @(negedge clk);
        data_in1 = 8'h01; data_in2 = 8'h02; mode = 2'b00; shamt = 3'd0;
        data_in1_valid = 1'b1; data_in2_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        data_in1_valid = 1'b0; data_in2_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [15:0] prev;
    logic [7:0]  cnt;
    logic [15:0] held;

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; data_in1_valid = 1'b0; data_in2_valid = 1'b0;
        data_in1 = 8'h00; data_in2 = 8'h00; mode = 2'b00; shamt = 3'd0; out_ready = 1'b0;

        vecs[0] = '{8'hA5, 8'h3C, 2'b00, 3'd0, 16'hA53C};
        vecs[1] = '{8'h81, 8'h00, 2'b01, 3'd2, 16'h0204};
        vecs[2] = '{8'hFF, 8'h55, 2'b01, 3'd7, 16'h7F80};
        vecs[3] = '{8'h12, 8'h34, 2'b10, 3'd4, 16'h2341};
        vecs[4] = '{8'h12, 8'h34, 2'b10, 3'd0, 16'h1234};
        vecs[5] = '{8'hFF, 8'hFF, 2'b11, 3'd3, 16'hFE01};
        vecs[6] = '{8'h00, 8'h9C, 2'b11, 3'd1, 16'h0000};
        vecs[7] = '{8'h80, 8'h01, 2'b10, 3'd7, 16'h00C0};
        vecs[8] = '{8'h5A, 8'hC3, 2'b00, 3'd5, 16'h5AC3};

        repeat (3) @(negedge clk);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_valid", 32'(output_valid), 32'd0);
        chk("reset_count", 32'(result_count), 32'd0);
        chk("reset_ready", 32'(data_in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;

        prev = 16'h0000;
        cnt  = 8'd0;
        for (int i = 0; i < 9; i++) begin
            cnt = cnt + 8'd1;
            run_vec(vecs[i], prev, cnt);
            prev = vecs[i].exp;
        end

        // Back-pressure: result held, pending operands blocked until acceptance.
        @(negedge clk);
        data_in1 = 8'hDE; data_in2 = 8'hAD; mode = 2'b00; shamt = 3'd0;
        data_in1_valid = 1'b1; data_in2_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        data_in1 = 8'h11; data_in2 = 8'h22; mode = 2'b00;
        repeat (2) @(negedge clk);
        held = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", 32'(output_valid), 32'd1);
            chk("bp_data_held", 32'(data_out), 32'(held));
            chk("bp_ready_low", 32'(data_in_ready), 32'd0);
            chk("bp_count_held", 32'(result_count), 32'(cnt));
            @(negedge clk);
        end
        $display("backpressure held data_out=%04h for 5 cycles", data_out);
        out_ready = 1'b1;
        @(negedge clk);
        cnt = cnt + 8'd1;
        chk("bp_accept_valid_low", 32'(output_valid), 32'd0);
        chk("bp_accept_count", 32'(result_count), 32'(cnt));
        chk("bp_accept_ready", 32'(data_in_ready), 32'd1);
        @(negedge clk);
        data_in1_valid = 1'b0; data_in2_valid = 1'b0;
        chk("pending_captured_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        chk("pending_valid", 32'(output_valid), 32'd1);
        chk("pending_data", 32'(data_out), 32'h1122);
        @(negedge clk);
        cnt = cnt + 8'd1;
        chk("pending_count", 32'(result_count), 32'(cnt));
        $display("pending op 11/22 -> data_out=%04h count=%0d", data_out, result_count);

        // Only one valid: no capture.
        data_in1 = 8'h77; data_in2 = 8'h66; data_in1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("single_valid_idle", 32'(busy), 32'd0);
            chk("single_valid_ready", 32'(data_in_ready), 32'd1);
        end
        $display("single valid for 3 cycles: busy=%0d", busy);

        // Reset during SHIFT discards the in-flight operation.
        data_in2_valid = 1'b1;
        @(negedge clk);
        data_in1_valid = 1'b0; data_in2_valid = 1'b0;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_data", 32'(data_out), 32'd0);
        chk("midreset_valid", 32'(output_valid), 32'd0);
        chk("midreset_count", 32'(result_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_valid", 32'(output_valid), 32'd0);
        end
        $display("reset during SHIFT: data_out=%04h valid=%0d count=%0d",
                 data_out, output_valid, result_count);

        // Count wrap: 255 results then one more.
        for (int i = 0; i < 255; i++) quick_op();
        chk("count_255", 32'(result_count), 32'd255);
        quick_op();
        chk("count_wrap", 32'(result_count), 32'd0);
        $display("count wrap: result_count=%0d", result_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
